// File: rtl/reg_file.sv
// Architectural register file with rename status for the Tomasulo core.
// Two combinational source queries with commit bypass; rename on issue, clear on commit or flush.
module reg_file #(
    parameter int REG_NUM   = 32,
    parameter int DATA_W    = 32,
    parameter int ROB_TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [4:0]           in_decode_tag1,
    output logic [DATA_W-1:0]    out_decode_value1,
    output logic [ROB_TAG_W-1:0] out_decode_robtag1,
    output logic                 out_decode_busy1,
    input  logic [4:0]           in_decode_tag2,
    output logic [DATA_W-1:0]    out_decode_value2,
    output logic [ROB_TAG_W-1:0] out_decode_robtag2,
    output logic                 out_decode_busy2,
    input  logic [4:0]           in_decode_destination,
    input  logic [ROB_TAG_W-1:0] in_decode_rob_tag,
    input  logic [4:0]           in_rob_commit_destination,
    input  logic [ROB_TAG_W-1:0] in_rob_commit_tag,
    input  logic [DATA_W-1:0]    in_rob_commit_value,
    input  logic                 in_rob_flush
);

    localparam int OUT_W = DATA_W + 1 + ROB_TAG_W;

    logic [DATA_W-1:0]    r_value [REG_NUM];
    logic [REG_NUM-1:0]   r_busy;
    logic [ROB_TAG_W-1:0] r_tag   [REG_NUM];

    logic [REG_NUM-1:0]   w_busy_nxt;
    logic [ROB_TAG_W-1:0] w_tag_nxt [REG_NUM];
    logic [OUT_W-1:0]     w_q1;
    logic [OUT_W-1:0]     w_q2;

    // A commit that retires the pending producer forwards its value in the same cycle.
    function automatic logic [OUT_W-1:0] f_query(
        input logic [4:0]           idx,
        input logic [DATA_W-1:0]    val,
        input logic                 busy,
        input logic [ROB_TAG_W-1:0] tag,
        input logic [4:0]           cdest,
        input logic [ROB_TAG_W-1:0] ctag,
        input logic [DATA_W-1:0]    cval
    );
        logic [OUT_W-1:0] res;
        if (idx == 5'd0) begin
            res = '0;
        end else if ((cdest == idx) && busy && (ctag == tag)) begin
            res = {cval, 1'b0, {ROB_TAG_W{1'b0}}};
        end else if (busy) begin
            res = {val, 1'b1, tag};
        end else begin
            res = {val, 1'b0, {ROB_TAG_W{1'b0}}};
        end
        return res;
    endfunction

    // Source operand queries.
    always_comb begin
        w_q1 = f_query(in_decode_tag1, r_value[in_decode_tag1], r_busy[in_decode_tag1],
                       r_tag[in_decode_tag1], in_rob_commit_destination,
                       in_rob_commit_tag, in_rob_commit_value);
        w_q2 = f_query(in_decode_tag2, r_value[in_decode_tag2], r_busy[in_decode_tag2],
                       r_tag[in_decode_tag2], in_rob_commit_destination,
                       in_rob_commit_tag, in_rob_commit_value);
    end

    assign {out_decode_value1, out_decode_busy1, out_decode_robtag1} = w_q1;
    assign {out_decode_value2, out_decode_busy2, out_decode_robtag2} = w_q2;

    // Rename status next state: flush beats issue, issue beats a same-register commit.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            w_busy_nxt[i] = r_busy[i];
            w_tag_nxt[i]  = r_tag[i];
            if (i == 0) begin
                w_busy_nxt[i] = 1'b0;
                w_tag_nxt[i]  = '0;
            end else if (in_rob_flush) begin
                w_busy_nxt[i] = 1'b0;
                w_tag_nxt[i]  = '0;
            end else if (in_decode_destination == 5'(i)) begin
                w_busy_nxt[i] = 1'b1;
                w_tag_nxt[i]  = in_decode_rob_tag;
            end else if ((in_rob_commit_destination == 5'(i)) && r_busy[i]
                         && (r_tag[i] == in_rob_commit_tag)) begin
                w_busy_nxt[i] = 1'b0;
                w_tag_nxt[i]  = '0;
            end else begin
                w_busy_nxt[i] = r_busy[i];
                w_tag_nxt[i]  = r_tag[i];
            end
        end
    end

    // State registers; committed values are written even under flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else if (rdy) begin
            r_busy <= w_busy_nxt;
            for (int i = 0; i < REG_NUM; i++) begin
                r_tag[i] <= w_tag_nxt[i];
                if ((i != 0) && (in_rob_commit_destination == 5'(i))) begin
                    r_value[i] <= in_rob_commit_value;
                end else begin
                    r_value[i] <= r_value[i];
                end
            end
        end else begin
            r_busy <= r_busy;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios with literal expectations,
// then random traffic compared every cycle against an array-based model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [4:0]  in_decode_tag1, in_decode_tag2;
    logic [31:0] out_decode_value1, out_decode_value2;
    logic [3:0]  out_decode_robtag1, out_decode_robtag2;
    logic        out_decode_busy1, out_decode_busy2;
    logic [4:0]  in_decode_destination;
    logic [3:0]  in_decode_rob_tag;
    logic [4:0]  in_rob_commit_destination;
    logic [3:0]  in_rob_commit_tag;
    logic [31:0] in_rob_commit_value;
    logic        in_rob_flush;

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_decode_tag1(in_decode_tag1), .out_decode_value1(out_decode_value1),
        .out_decode_robtag1(out_decode_robtag1), .out_decode_busy1(out_decode_busy1),
        .in_decode_tag2(in_decode_tag2), .out_decode_value2(out_decode_value2),
        .out_decode_robtag2(out_decode_robtag2), .out_decode_busy2(out_decode_busy2),
        .in_decode_destination(in_decode_destination), .in_decode_rob_tag(in_decode_rob_tag),
        .in_rob_commit_destination(in_rob_commit_destination),
        .in_rob_commit_tag(in_rob_commit_tag), .in_rob_commit_value(in_rob_commit_value),
        .in_rob_flush(in_rob_flush)
    );

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    logic [31:0] mval  [32];
    bit          mbusy [32];
    logic [3:0]  mtag  [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mval[i] = 32'd0; mbusy[i] = 1'b0; mtag[i] = 4'd0;
        end
    endtask

    function automatic void mquery(input logic [4:0] r, output logic [31:0] v,
                                   output logic b, output logic [3:0] t);
        if (r == 5'd0) begin
            v = 32'd0; b = 1'b0; t = 4'd0;
        end else if (in_rob_commit_destination == r && mbusy[r] && mtag[r] == in_rob_commit_tag) begin
            v = in_rob_commit_value; b = 1'b0; t = 4'd0;
        end else begin
            v = mval[r]; b = mbusy[r]; t = mbusy[r] ? mtag[r] : 4'd0;
        end
    endfunction

    task automatic model_update();
        if (rdy && !rst) begin
            if (in_rob_commit_destination != 5'd0) begin
                mval[in_rob_commit_destination] = in_rob_commit_value;
                if (mbusy[in_rob_commit_destination] &&
                    mtag[in_rob_commit_destination] == in_rob_commit_tag) begin
                    mbusy[in_rob_commit_destination] = 1'b0;
                    mtag[in_rob_commit_destination]  = 4'd0;
                end
            end
            if (in_rob_flush) begin
                for (int i = 0; i < 32; i++) begin mbusy[i] = 1'b0; mtag[i] = 4'd0; end
            end else if (in_decode_destination != 5'd0) begin
                mbusy[in_decode_destination] = 1'b1;
                mtag[in_decode_destination]  = in_decode_rob_tag;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1;
        in_decode_destination = 5'd0; in_decode_rob_tag = 4'd0;
        in_rob_commit_destination = 5'd0; in_rob_commit_tag = 4'd0;
        in_rob_commit_value = 32'd0; in_rob_flush = 1'b0;
    endtask

    // Literal check of one query port for register r.
    task automatic qchk(input string nm, input bit port2, input logic [4:0] r,
                        input logic [31:0] ev, input logic eb, input logic [3:0] et);
        if (port2) in_decode_tag2 = r; else in_decode_tag1 = r;
        #1;
        chk({nm, "_value"}, port2 ? out_decode_value2 : out_decode_value1, ev);
        chk({nm, "_busy"}, 32'(port2 ? out_decode_busy2 : out_decode_busy1), 32'(eb));
        chk({nm, "_robtag"}, 32'(port2 ? out_decode_robtag2 : out_decode_robtag1), 32'(et));
    endtask

    always @(negedge clk) begin
        logic [31:0] v; logic b; logic [3:0] t;
        if (cmp_en) begin
            mquery(in_decode_tag1, v, b, t);
            chk("model_q1_value", out_decode_value1, v);
            chk("model_q1_busy", 32'(out_decode_busy1), 32'(b));
            chk("model_q1_robtag", 32'(out_decode_robtag1), 32'(t));
            mquery(in_decode_tag2, v, b, t);
            chk("model_q2_value", out_decode_value2, v);
            chk("model_q2_busy", 32'(out_decode_busy2), 32'(b));
            chk("model_q2_robtag", 32'(out_decode_robtag2), 32'(t));
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        in_decode_tag1 = 5'd0; in_decode_tag2 = 5'd0;
        model_reset();
        cmp_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        qchk("reset_x5", 1'b0, 5'd5, 32'd0, 1'b0, 4'd0);

        // Issue then commit with bypass
        in_decode_destination = 5'd5; in_decode_rob_tag = 4'd3;
        tick(); idle();
        qchk("issue_x5", 1'b0, 5'd5, 32'd0, 1'b1, 4'd3);
        in_rob_commit_destination = 5'd5; in_rob_commit_tag = 4'd3;
        in_rob_commit_value = 32'hDEADBEEF;
        qchk("bypass_x5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);
        tick(); idle();
        qchk("commit_x5", 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);

        // Stale commit leaves younger rename pending
        in_decode_destination = 5'd7; in_decode_rob_tag = 4'd2; tick();
        in_decode_rob_tag = 4'd5; tick(); idle();
        in_rob_commit_destination = 5'd7; in_rob_commit_tag = 4'd2;
        in_rob_commit_value = 32'h11;
        qchk("stale_bypass_x7", 1'b1, 5'd7, 32'd0, 1'b1, 4'd5);
        tick(); idle();
        qchk("stale_x7", 1'b0, 5'd7, 32'h11, 1'b1, 4'd5);

        // Same-cycle issue and commit on x9
        in_decode_destination = 5'd9; in_decode_rob_tag = 4'd4; tick();
        in_decode_rob_tag = 4'd6;
        in_rob_commit_destination = 5'd9; in_rob_commit_tag = 4'd4;
        in_rob_commit_value = 32'h22;
        tick(); idle();
        qchk("issue_commit_x9", 1'b1, 5'd9, 32'h22, 1'b1, 4'd6);

        // Flush with concurrent issue and commit
        for (int i = 1; i <= 3; i++) begin
            in_decode_destination = 5'(i); in_decode_rob_tag = 4'(i); tick();
        end
        idle();
        in_rob_flush = 1'b1; in_decode_destination = 5'd4; in_decode_rob_tag = 4'd1;
        in_rob_commit_destination = 5'd2; in_rob_commit_tag = 4'd2;
        in_rob_commit_value = 32'h33;
        tick(); idle();
        qchk("flush_x1", 1'b0, 5'd1, 32'd0, 1'b0, 4'd0);
        qchk("flush_x2", 1'b1, 5'd2, 32'h33, 1'b0, 4'd0);
        qchk("flush_x3", 1'b0, 5'd3, 32'd0, 1'b0, 4'd0);
        qchk("flush_x4", 1'b1, 5'd4, 32'd0, 1'b0, 4'd0);

        // x0 writes ignored; rdy low holds state
        in_rob_commit_value = 32'hFF; tick(); idle();
        qchk("x0_p1", 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        qchk("x0_p2", 1'b1, 5'd0, 32'd0, 1'b0, 4'd0);
        rdy = 1'b0; in_decode_destination = 5'd8; in_decode_rob_tag = 4'd1;
        tick(); idle();
        qchk("rdy_low_x8", 1'b0, 5'd8, 32'd0, 1'b0, 4'd0);

        // Asynchronous reset mid-cycle with renames outstanding
        in_decode_destination = 5'd5; in_decode_rob_tag = 4'd7; tick(); idle();
        in_rob_commit_destination = 5'd9; in_rob_commit_tag = 4'd3;
        in_rob_commit_value = 32'h1234; tick(); idle();
        in_decode_tag1 = 5'd5; in_decode_tag2 = 5'd9;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_v1", out_decode_value1, 32'd0);
        chk("async_rst_b1", 32'(out_decode_busy1), 32'd0);
        chk("async_rst_t1", 32'(out_decode_robtag1), 32'd0);
        chk("async_rst_v2", out_decode_value2, 32'd0);
        tick();
        rst = 1'b0;
        qchk("post_rst_x5", 1'b0, 5'd5, 32'd0, 1'b0, 4'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] r;
            rdy = ($urandom_range(0, 9) != 0);
            in_rob_flush = ($urandom_range(0, 49) == 0);
            in_decode_tag1 = 5'($urandom_range(0, 31));
            in_decode_tag2 = 5'($urandom_range(0, 31));
            in_decode_destination = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            in_decode_rob_tag = 4'($urandom);
            r = 5'($urandom_range(1, 31));
            in_rob_commit_destination = ($urandom_range(0, 3) == 0) ? 5'd0 : r;
            in_rob_commit_tag = (mbusy[r] && $urandom_range(0, 9) < 7) ? mtag[r] : 4'($urandom);
            in_rob_commit_value = $urandom;
            if ($urandom_range(0, 2) == 0) in_decode_tag1 = r;
            tick();
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
